// File: rtl/rf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rf_ctrl_pkg
// Shared widths and the register-file write request type used by the write
// arbiter and its result buffer.
//   XLEN        : register data width
//   REG_AW      : register address width
//   rf_wr_req_t : {rd, data} write request held in the result buffer
// -----------------------------------------------------------------------------
package rf_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// -----------------------------------------------------------------------------
// rf_wr_fifo
// Circular FIFO of DEPTH register-file write requests. Pointers wrap modulo
// DEPTH (power of 2). Also exposes every slot's valid bit and rd so the
// parent can run a hazard compare against all buffered destinations.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (flushes buffer)
//   push_i          : write push_req_i at the tail (caller guarantees not full)
//   push_req_i      : request to enqueue
//   pop_i           : drop the head (caller guarantees not empty)
//   head_o          : oldest entry
//   count_o         : number of valid entries
//   entry_valid_o   : per-slot valid, indexed by physical slot
//   entry_rd_o      : per-slot destination register, indexed by physical slot
// -----------------------------------------------------------------------------
module rf_wr_fifo
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_i,
    input  rf_wr_req_t                       push_req_i,
    input  logic                             pop_i,
    output rf_wr_req_t                       head_o,
    output logic [$clog2(DEPTH):0]           count_o,
    output logic [DEPTH-1:0]                 entry_valid_o,
    output logic [DEPTH-1:0][REG_AW-1:0]     entry_rd_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    rf_wr_req_t    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_i && !rst) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A slot is live when its distance from the head is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [PW-1:0] entry_off;
        assign entry_off        = PW'(g) - rd_ptr_q;
        assign entry_valid_o[g] = {1'b0, entry_off} < count_q;
        assign entry_rd_o[g]    = mem_q[g].rd;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single register-file write port between the WB stage and a
// multi-cycle unit. Multi-cycle results go through a small FIFO; WB wins the
// port unless the buffered head has waited MAX_WAIT cycles, in which case WB
// is frozen for one cycle (stall_wb) and the head is written instead.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   wb_en, wb_rd, wb_data           : WB write request (rd 0 is ignored)
//   mc_valid, mc_ready, mc_rd,
//   mc_data                         : multi-cycle result handshake
//   rs1_address, rs2_address        : decode reads checked against the buffer
//   en, rd, register_file_data      : register-file write port
//   stall_wb                        : WB must hold and re-present next cycle
//   pending_hazard                  : a non-zero rs matches a buffered rd
//   buf_count                       : buffered entries
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en,
    input  logic [REG_AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [REG_AW-1:0]        mc_rd,
    input  logic [XLEN-1:0]          mc_data,
    input  logic [REG_AW-1:0]        rs1_address,
    input  logic [REG_AW-1:0]        rs2_address,
    output logic                     en,
    output logic [REG_AW-1:0]        rd,
    output logic [XLEN-1:0]          register_file_data,
    output logic                     stall_wb,
    output logic                     pending_hazard,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic                          fifo_push;
    logic                          fifo_pop;
    rf_wr_req_t                    fifo_req;
    rf_wr_req_t                    fifo_head;
    logic [CW-1:0]                 fifo_count;
    logic [DEPTH-1:0]              entry_valid;
    logic [DEPTH-1:0][REG_AW-1:0]  entry_rd;

    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          wb_act;
    logic          buf_nempty;
    logic          starve;

    assign fifo_req = '{rd: mc_rd, data: mc_data};

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (fifo_push),
        .push_req_i    (fifo_req),
        .pop_i         (fifo_pop),
        .head_o        (fifo_head),
        .count_o       (fifo_count),
        .entry_valid_o (entry_valid),
        .entry_rd_o    (entry_rd)
    );

    assign wb_act     = wb_en && (wb_rd != '0);
    assign buf_nempty = (fifo_count != '0);
    assign starve     = buf_nempty && (wait_cnt_q == WW'(MAX_WAIT));

    // A full buffer refuses results even if the head pops this cycle.
    assign mc_ready  = !rst && (fifo_count < CW'(DEPTH));
    // rd 0 results are acknowledged but never stored.
    assign fifo_push = mc_valid && mc_ready && (mc_rd != '0);
    assign buf_count = rst ? '0 : fifo_count;

    // Write-port grant: starving head, then WB, then any buffered head.
    always_comb begin
        en                 = 1'b0;
        rd                 = '0;
        register_file_data = '0;
        stall_wb           = 1'b0;
        fifo_pop           = 1'b0;
        if (!rst) begin
            if (starve) begin
                en                 = 1'b1;
                rd                 = fifo_head.rd;
                register_file_data = fifo_head.data;
                stall_wb           = 1'b1;
                fifo_pop           = 1'b1;
            end else if (wb_act) begin
                en                 = 1'b1;
                rd                 = wb_rd;
                register_file_data = wb_data;
            end else if (buf_nempty) begin
                en                 = 1'b1;
                rd                 = fifo_head.rd;
                register_file_data = fifo_head.data;
                fifo_pop           = 1'b1;
            end
        end
    end

    // Counts cycles the current head is passed over; a new head starts at 0.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (fifo_pop || !buf_nempty) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WW'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Only registered entries count; a result accepted this cycle is not yet visible.
    always_comb begin
        pending_hazard = 1'b0;
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entry_valid[i] &&
                    (((rs1_address != '0) && (entry_rd[i] == rs1_address)) ||
                     ((rs2_address != '0) && (entry_rd[i] == rs2_address)))) begin
                    pending_hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
    import rf_ctrl_pkg::*;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              mc_valid;
    logic              mc_ready;
    logic [REG_AW-1:0] mc_rd;
    logic [XLEN-1:0]   mc_data;
    logic [REG_AW-1:0] rs1_address;
    logic [REG_AW-1:0] rs2_address;
    logic              en;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   register_file_data;
    logic              stall_wb;
    logic              pending_hazard;
    logic [CW-1:0]     buf_count;

    int n_checks = 0;
    int n_errors = 0;

    rf_write_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .wb_en              (wb_en),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data),
        .mc_valid           (mc_valid),
        .mc_ready           (mc_ready),
        .mc_rd              (mc_rd),
        .mc_data            (mc_data),
        .rs1_address        (rs1_address),
        .rs2_address        (rs2_address),
        .en                 (en),
        .rd                 (rd),
        .register_file_data (register_file_data),
        .stall_wb           (stall_wb),
        .pending_hazard     (pending_hazard),
        .buf_count          (buf_count)
    );

    always #5 clk = ~clk;

    // Register file fed by the arbiter's write port.
    logic [XLEN-1:0] rf_mem [32];
    always @(posedge clk) begin
        if (en) rf_mem[rd] <= register_file_data;
    end

    typedef struct {
        logic        rst;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        mc_valid;
        logic [4:0]  mc_rd;
        logic [31:0] mc_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_ready;
        logic        e_stall;
        logic        e_haz;
        int          e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic we, input logic [4:0] wrd,
                          input logic [31:0] wd, input logic mv, input logic [4:0] mrd,
                          input logic [31:0] md, input logic [4:0] r1, input logic [4:0] r2);
        rst = r; wb_en = we; wb_rd = wrd; wb_data = wd;
        mc_valid = mv; mc_rd = mrd; mc_data = md;
        rs1_address = r1; rs2_address = r2;
    endtask

    task automatic chk_out(input string name, input logic e_en, input logic [4:0] e_rd,
                           input logic [31:0] e_data, input logic e_ready, input logic e_stall,
                           input logic e_haz, input int e_cnt);
        check($sformatf("%s.en", name), 32'(en), 32'(e_en));
        check($sformatf("%s.rd", name), 32'(rd), 32'(e_rd));
        check($sformatf("%s.data", name), register_file_data, e_data);
        check($sformatf("%s.mc_ready", name), 32'(mc_ready), 32'(e_ready));
        check($sformatf("%s.stall_wb", name), 32'(stall_wb), 32'(e_stall));
        check($sformatf("%s.hazard", name), 32'(pending_hazard), 32'(e_haz));
        check($sformatf("%s.buf_count", name), 32'(buf_count), 32'(e_cnt));
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Reference model: buffered results as a queue plus the head's wait age.
    logic [4:0]  q_rd [$];
    logic [31:0] q_data [$];
    int          m_wait;

    task automatic model_cycle(input string name);
        int          cnt;
        logic        e_en, e_stall, e_haz, e_ready, pop;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        cnt = q_rd.size();
        e_en = 0; e_rd = 0; e_data = 0; e_stall = 0; e_haz = 0; e_ready = 0; pop = 0;
        if (rst) begin
            cnt = 0;
        end else begin
            if (cnt > 0 && m_wait == MAX_WAIT) begin
                e_en = 1; e_rd = q_rd[0]; e_data = q_data[0]; e_stall = 1; pop = 1;
            end else if (wb_en && wb_rd != 0) begin
                e_en = 1; e_rd = wb_rd; e_data = wb_data;
            end else if (cnt > 0) begin
                e_en = 1; e_rd = q_rd[0]; e_data = q_data[0]; pop = 1;
            end
            e_ready = (cnt < DEPTH);
            foreach (q_rd[i]) begin
                if ((rs1_address != 0 && q_rd[i] == rs1_address) ||
                    (rs2_address != 0 && q_rd[i] == rs2_address)) e_haz = 1;
            end
        end
        chk_out(name, e_en, e_rd, e_data, e_ready, e_stall, e_haz, cnt);
        if (rst) begin
            q_rd.delete(); q_data.delete(); m_wait = 0;
        end else begin
            if (pop) begin
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
            end
            if (mc_valid && e_ready && mc_rd != 0) begin
                q_rd.push_back(mc_rd);
                q_data.push_back(mc_data);
            end
            if (pop || cnt == 0) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
        end
    endtask

    vec_t vecs [9];

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;

        // rst, wb_en, wb_rd, wb_data, mc_v, mc_rd, mc_data, rs1, rs2 | en, rd, data, rdy, stall, haz, cnt
        vecs[0] = '{1, 1, 5, 32'h1, 1, 4, 32'hAA, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 1, 5, 32'h1, 1, 4, 32'hAA, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,  1, 5, 32'hDEADBEEF, 1, 0, 0, 0};
        vecs[3] = '{0, 0, 0, 0, 1, 7, 32'h1234, 5, 0,  0, 0, 0, 1, 0, 0, 0};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 7, 0,  1, 7, 32'h1234, 1, 0, 1, 1};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 7, 0,  0, 0, 0, 1, 0, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 1, 0, 32'h55, 0, 0,  0, 0, 0, 1, 0, 0, 0};
        vecs[7] = '{0, 1, 0, 32'h99, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0};

        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        next();
        foreach (vecs[i]) begin
            set_in(vecs[i].rst, vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_data, vecs[i].mc_valid,
                   vecs[i].mc_rd, vecs[i].mc_data, vecs[i].rs1, vecs[i].rs2);
            mid();
            chk_out($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_rd, vecs[i].e_data,
                    vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_haz, vecs[i].e_cnt);
            if (i == 3) check("rf_read_x5", rf_mem[5], 32'hDEADBEEF);
            next();
        end
        check("rf_x7", rf_mem[7], 32'h1234);
        check("rf_x0_untouched", rf_mem[0], 32'h0);

        // Starvation: WB writes x3 every cycle, buffered x9 forced out after MAX_WAIT waits.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); next(); next();
        set_in(0, 1, 3, 32'h33, 1, 9, 32'h99, 0, 0);
        mid(); chk_out("starve_t0", 1, 3, 32'h33, 1, 0, 0, 0); next();
        for (int k = 1; k <= 4; k++) begin
            set_in(0, 1, 3, 32'h33 + k, 0, 0, 0, 0, 0);
            mid(); chk_out($sformatf("starve_t%0d", k), 1, 3, 32'h33 + k, 1, 0, 0, 1); next();
        end
        set_in(0, 1, 3, 32'h40, 0, 0, 0, 0, 0);
        mid(); chk_out("starve_t5", 1, 9, 32'h99, 1, 1, 0, 1); next();
        mid(); chk_out("starve_t6", 1, 3, 32'h40, 1, 0, 0, 0); next();

        // Full buffer, held third result and hazard compare.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); next(); next();
        set_in(0, 1, 3, 32'h1, 1, 9, 32'h90, 0, 0);
        mid(); chk_out("full_a", 1, 3, 32'h1, 1, 0, 0, 0); next();
        set_in(0, 1, 3, 32'h2, 1, 10, 32'hA0, 0, 0);
        mid(); chk_out("full_b", 1, 3, 32'h2, 1, 0, 0, 1); next();
        set_in(0, 1, 3, 32'h3, 1, 11, 32'hB0, 0, 10);
        mid(); chk_out("full_c", 1, 3, 32'h3, 0, 0, 1, 2); next();
        set_in(0, 1, 3, 32'h4, 1, 11, 32'hB0, 0, 0);
        mid(); chk_out("full_d", 1, 3, 32'h4, 0, 0, 0, 2); next();
        set_in(0, 1, 3, 32'h5, 1, 11, 32'hB0, 9, 0);
        mid(); chk_out("full_e", 1, 3, 32'h5, 0, 0, 1, 2); next();
        set_in(0, 1, 3, 32'h6, 1, 11, 32'hB0, 0, 0);
        mid(); chk_out("full_f_pop_not_ready", 1, 9, 32'h90, 0, 1, 0, 2); next();
        set_in(0, 1, 3, 32'h6, 1, 11, 32'hB0, 0, 0);
        mid(); chk_out("full_g", 1, 3, 32'h6, 1, 0, 0, 1); next();

        // Randomized traffic against the queue model.
        q_rd.delete(); q_data.delete(); m_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            set_in((c == 0) || ($urandom_range(0, 99) == 0),
                   $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            mid();
            model_cycle($sformatf("rand%0d", c));
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
